// File: rtl/axi_slave_rd.sv
// AXI4 read-channel responder: serves one AR burst at a time from a 1-cycle-latency memory
// read port, buffering R beats in a small FIFO so memory reads never stall on backpressure.
module axi_slave_rd #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned BEAT_BYTES  = 8,
   parameter logic [1:0]  RESP_OKAY   = 2'b00,
   parameter logic [1:0]  RESP_SLVERR = 2'b10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  s_axi_arid,
   input  logic [29:0] s_axi_araddr,
   input  logic [7:0]  s_axi_arlen,
   input  logic [2:0]  s_axi_arsize,
   input  logic [1:0]  s_axi_arburst,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [3:0]  s_axi_rid,
   output logic [63:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rlast,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic        mem_rd_en,
   output logic [29:0] mem_rd_addr,
   input  logic [63:0] mem_rd_data
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned FW = 64 + 2 + 1;
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]    r_state;
   logic          r_arready;
   logic [3:0]    r_id;
   logic [29:0]   r_addr;
   logic [7:0]    r_len;
   logic [1:0]    r_burst;
   logic          r_err;
   logic [8:0]    r_issued;
   logic          r_inflight;
   logic          r_infl_last;
   logic          r_infl_err;
   logic [FW-1:0] r_fifo [FIFO_DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [PW:0]   r_count;

   logic          w_ar_hs;
   logic          w_pop;
   logic          w_push;
   logic          w_last_hs;
   logic          w_issue;
   logic          w_rvalid;
   logic [FW-1:0] w_head;
   logic [FW-1:0] w_push_word;

   assign w_rvalid  = (r_count != '0);
   assign w_head    = r_fifo[r_rptr];
   assign w_ar_hs   = s_axi_arvalid && r_arready;
   assign w_pop     = w_rvalid && s_axi_rready;
   assign w_push    = r_inflight;
   assign w_last_hs = w_pop && w_head[0] && (r_state == S_RUN);

   // The pending memory read holds a FIFO credit until its data lands.
   assign w_issue = (r_state == S_RUN) && (r_issued <= {1'b0, r_len}) &&
                    ((r_count + {{PW{1'b0}}, r_inflight}) < DEPTH_C);

   assign w_push_word = {(r_infl_err ? 64'd0 : mem_rd_data),
                         (r_infl_err ? RESP_SLVERR : RESP_OKAY),
                         r_infl_last};

   assign s_axi_arready = r_arready;
   assign s_axi_rid     = r_id;
   assign s_axi_rvalid  = w_rvalid;
   assign s_axi_rdata   = w_rvalid ? w_head[FW-1:3] : '0;
   assign s_axi_rresp   = w_rvalid ? w_head[2:1] : '0;
   assign s_axi_rlast   = w_rvalid && w_head[0];
   assign mem_rd_en     = w_issue && !r_err;
   assign mem_rd_addr   = r_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_arready <= 1'b0;
      end else if (w_ar_hs) begin
         r_state   <= S_RUN;
         r_arready <= 1'b0;
      end else if (w_last_hs) begin
         r_state   <= S_IDLE;
         r_arready <= 1'b1;
      end else if (r_state == S_IDLE) begin
         r_arready <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_id     <= '0;
         r_addr   <= '0;
         r_len    <= '0;
         r_burst  <= '0;
         r_err    <= 1'b0;
         r_issued <= '0;
      end else if (w_ar_hs) begin
         r_id     <= s_axi_arid;
         r_addr   <= s_axi_araddr;
         r_len    <= s_axi_arlen;
         r_burst  <= s_axi_arburst;
         r_err    <= (s_axi_arsize != 3'b011) || (s_axi_arburst == 2'b11);
         r_issued <= '0;
      end else if (w_issue) begin
         r_issued <= r_issued + 9'd1;
         if (r_burst != 2'b00)
            r_addr <= r_addr + 30'(BEAT_BYTES);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight  <= 1'b0;
         r_infl_last <= 1'b0;
         r_infl_err  <= 1'b0;
      end else begin
         r_inflight  <= w_issue;
         r_infl_last <= (r_issued == {1'b0, r_len});
         r_infl_err  <= r_err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + PW'(1);
         if (w_pop)
            r_rptr <= r_rptr + PW'(1);
         if (w_push && !w_pop)
            r_count <= r_count + (PW+1)'(1);
         else if (w_pop && !w_push)
            r_count <= r_count - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_fifo[r_wptr] <= w_push_word;
   end

endmodule
